// File: rtl/heston_pkg.sv
// heston_pkg: shared definitions for the Heston path sequencer.
//   - Q8.24 fixed-point constants
//   - controller state encoding
//   - payoff_q824(): European payoff max(+/-(S-K), 0) on Q8.24 operands,
//     returned as a non-negative 33-bit value
package heston_pkg;

    localparam int unsigned FRAC_BITS = 24;
    localparam logic [31:0] Q_ONE     = 32'h0100_0000;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        STEP,
        WAIT,
        PAYOFF,
        DONE
    } state_t;

    // The difference is taken at 33 bits so that extreme Q8.24 operands
    // cannot wrap before the sign test.
    function automatic logic [32:0] payoff_q824(input logic [31:0] S,
                                                input logic [31:0] K,
                                                input logic        is_put);
        logic [32:0] d;
        if (is_put) begin
            d = {K[31], K} - {S[31], S};
        end else begin
            d = {S[31], S} - {K[31], K};
        end
        if (!d[32] && (d != '0)) begin
            return d;
        end
        return '0;
    endfunction

endpackage

// File: rtl/heston_path_ctrl_payoff_acc.sv
// heston_payoff_acc: payoff evaluation plus signed SUM_W accumulator.
//   clk, rst   : clock, synchronous active-high reset
//   clr_i      : clear the accumulator (takes priority over add_i)
//   add_i      : add payoff(S_i, K_i, is_put_i) to the accumulator
//   S_i, K_i   : Q8.24 signed stock price and strike
//   is_put_i   : 0 = call, 1 = put
//   sum_o      : accumulated payoff, signed Q(SUM_W-24).24, wraps on overflow
module heston_payoff_acc
    import heston_pkg::*;
#(
    parameter int unsigned SUM_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             add_i,
    input  logic [31:0]      S_i,
    input  logic [31:0]      K_i,
    input  logic             is_put_i,
    output logic [SUM_W-1:0] sum_o
);

    logic [32:0]      payoff;
    logic [SUM_W-1:0] payoff_ext;
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_d;

    always_comb begin
        payoff     = payoff_q824(S_i, K_i, is_put_i);
        payoff_ext = {{(SUM_W-33){payoff[32]}}, payoff};
    end

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (add_i) begin
            sum_d = sum_q + payoff_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/heston_path_ctrl.sv
// heston_path_ctrl: Monte-Carlo path sequencer around the Euler-step Heston
// SDE solver. Per path: load S0/v0, run n_steps solver steps (one RNG pair
// each), then accumulate the European payoff. Repeats for n_paths paths.
//   clk, rst                 : clock, synchronous active-high reset
//   start                    : begin a run (sampled only in IDLE)
//   S0, v0, K                : Q8.24 initial price, initial variance, strike
//   is_put                   : 0 = call, 1 = put
//   n_steps, n_paths         : steps per path, number of paths
//   rng_valid / rng_ready    : RNG pair handshake (data goes to the solver)
//   solver_en                : solver step enable
//   solver_S, solver_v       : current path state to the solver
//   solver_S_out/v_out       : solver registered results
//   busy, done               : activity flag, one-cycle end-of-run pulse
//   payoff_sum, path_count   : accumulated payoff, completed paths
module heston_path_ctrl
    import heston_pkg::*;
#(
    parameter int unsigned STEP_W = 16,
    parameter int unsigned PATH_W = 16,
    parameter int unsigned SUM_W  = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       S0,
    input  logic [31:0]       v0,
    input  logic [31:0]       K,
    input  logic              is_put,
    input  logic [STEP_W-1:0] n_steps,
    input  logic [PATH_W-1:0] n_paths,
    input  logic              rng_valid,
    output logic              rng_ready,
    output logic              solver_en,
    output logic [31:0]       solver_S,
    output logic [31:0]       solver_v,
    input  logic [31:0]       solver_S_out,
    input  logic [31:0]       solver_v_out,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  payoff_sum,
    output logic [PATH_W-1:0] path_count
);

    state_t            state_q, state_d;
    logic [31:0]       S_q, S_d;
    logic [31:0]       v_q, v_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [PATH_W-1:0] path_cnt_q, path_cnt_d;

    // Configuration captured on an accepted start
    logic [31:0]       S0_l_q, v0_l_q, K_l_q;
    logic              is_put_l_q;
    logic [STEP_W-1:0] n_steps_l_q;
    logic [PATH_W-1:0] n_paths_l_q;

    logic              latch_cfg;
    logic              acc_clr;
    logic              acc_add;
    logic [STEP_W-1:0] step_inc;
    logic [PATH_W-1:0] path_inc;

    assign step_inc = step_cnt_q + STEP_W'(1);
    assign path_inc = path_cnt_q + PATH_W'(1);

    always_comb begin
        state_d    = state_q;
        S_d        = S_q;
        v_d        = v_q;
        step_cnt_d = step_cnt_q;
        path_cnt_d = path_cnt_q;
        latch_cfg  = 1'b0;
        acc_clr    = 1'b0;
        acc_add    = 1'b0;
        rng_ready  = 1'b0;
        solver_en  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    latch_cfg  = 1'b1;
                    acc_clr    = 1'b1;
                    path_cnt_d = '0;
                    // Decided on the live input: the latched copy is not yet valid
                    state_d    = (n_paths == '0) ? DONE : INIT;
                end
            end
            INIT: begin
                S_d        = S0_l_q;
                v_d        = v0_l_q;
                step_cnt_d = '0;
                state_d    = (n_steps_l_q == '0) ? PAYOFF : STEP;
            end
            STEP: begin
                rng_ready = 1'b1;
                solver_en = rng_valid;
                if (rng_valid) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Full-truncation floor: negative results clamp to zero
                S_d        = solver_S_out[31] ? '0 : solver_S_out;
                v_d        = solver_v_out[31] ? '0 : solver_v_out;
                step_cnt_d = step_inc;
                state_d    = (step_inc == n_steps_l_q) ? PAYOFF : STEP;
            end
            PAYOFF: begin
                acc_add    = 1'b1;
                path_cnt_d = path_inc;
                state_d    = (path_inc == n_paths_l_q) ? DONE : INIT;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            S_q        <= '0;
            v_q        <= '0;
            step_cnt_q <= '0;
            path_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            S_q        <= S_d;
            v_q        <= v_d;
            step_cnt_q <= step_cnt_d;
            path_cnt_q <= path_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            S0_l_q      <= '0;
            v0_l_q      <= '0;
            K_l_q       <= '0;
            is_put_l_q  <= 1'b0;
            n_steps_l_q <= '0;
            n_paths_l_q <= '0;
        end else if (latch_cfg) begin
            S0_l_q      <= S0;
            v0_l_q      <= v0;
            K_l_q       <= K;
            is_put_l_q  <= is_put;
            n_steps_l_q <= n_steps;
            n_paths_l_q <= n_paths;
        end
    end

    heston_payoff_acc #(
        .SUM_W (SUM_W)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (acc_clr),
        .add_i    (acc_add),
        .S_i      (S_q),
        .K_i      (K_l_q),
        .is_put_i (is_put_l_q),
        .sum_o    (payoff_sum)
    );

    assign solver_S   = S_q;
    assign solver_v   = v_q;
    assign path_count = path_cnt_q;

endmodule

// File: tb/tb_heston_path_ctrl.sv
// Testbench for heston_path_ctrl with a one-cycle registered stub solver.
module tb_heston_path_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] S0 = '0, v0 = '0, K = '0;
    logic        is_put = 1'b0;
    logic [15:0] n_steps = '0, n_paths = '0;
    logic        rng_valid = 1'b0;
    logic        rng_ready, solver_en, busy, done;
    logic [31:0] solver_S, solver_v;
    logic [31:0] solver_S_out = '0, solver_v_out = '0;
    logic [47:0] payoff_sum;
    logic [15:0] path_count;
    logic        stub_neg = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    heston_path_ctrl #(
        .STEP_W (16),
        .PATH_W (16),
        .SUM_W  (48)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .S0           (S0),
        .v0           (v0),
        .K            (K),
        .is_put       (is_put),
        .n_steps      (n_steps),
        .n_paths      (n_paths),
        .rng_valid    (rng_valid),
        .rng_ready    (rng_ready),
        .solver_en    (solver_en),
        .solver_S     (solver_S),
        .solver_v     (solver_v),
        .solver_S_out (solver_S_out),
        .solver_v_out (solver_v_out),
        .busy         (busy),
        .done         (done),
        .payoff_sum   (payoff_sum),
        .path_count   (path_count)
    );

    // Stub solver: registers S+0.25 (or fixed negative values) when enabled
    always @(posedge clk) begin
        if (solver_en) begin
            if (stub_neg) begin
                solver_S_out <= 32'hFFF0_0000;
                solver_v_out <= 32'hFF00_0000;
            end else begin
                solver_S_out <= solver_S + 32'h0040_0000;
                solver_v_out <= solver_v;
            end
        end
    end

    typedef struct {
        logic [15:0] n_steps;
        logic [15:0] n_paths;
        logic [31:0] s0;
        logic [31:0] v0;
        logic [31:0] k;
        logic        is_put;
        logic        stub_neg;
        logic [3:0]  pat;      // rng_valid for cycle index mod 4
        logic [47:0] exp_sum;
        logic [15:0] exp_pc;
        int          exp_en;
    } vec_t;

    typedef struct {
        logic [47:0] sum;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   cyc;
        int   done_cyc;
        int   en_cnt;
        int   ready_cnt;
        int   stall_cnt;
        int   exp_cyc;
        exp_t e;
        @(posedge clk); #1;
        S0 = v.s0; v0 = v.v0; K = v.k; is_put = v.is_put;
        n_steps = v.n_steps; n_paths = v.n_paths; stub_neg = v.stub_neg;
        rng_valid = v.pat[0];
        start = 1'b1;
        sb.push_back('{sum: v.exp_sum, pc: v.exp_pc});
        cyc = 0; done_cyc = -1; en_cnt = 0; ready_cnt = 0; stall_cnt = 0;
        while (cyc < 2000 && done_cyc < 0) begin
            @(negedge clk);
            if (cyc == 0) chk($sformatf("v%0d busy_at_start", idx), 64'(busy), 64'd0);
            chk($sformatf("v%0d en_handshake c%0d", idx, cyc), 64'(solver_en),
                64'(rng_ready && rng_valid));
            if (v.stub_neg && solver_en && en_cnt > 0) begin
                chk($sformatf("v%0d floor_S", idx), 64'(solver_S), 64'd0);
                chk($sformatf("v%0d floor_v", idx), 64'(solver_v), 64'd0);
            end
            if (rng_ready) ready_cnt++;
            if (solver_en) en_cnt++;
            if (rng_ready && !rng_valid) stall_cnt++;
            if (done) begin
                done_cyc = cyc;
                e = sb.pop_front();
                chk($sformatf("v%0d payoff_sum", idx), 64'(payoff_sum), 64'(e.sum));
                chk($sformatf("v%0d path_count", idx), 64'(path_count), 64'(e.pc));
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            rng_valid = v.pat[cyc % 4];
        end
        if (done_cyc < 0) begin
            chk($sformatf("v%0d done_timeout", idx), 64'd0, 64'd1);
            void'(sb.pop_front());
        end else begin
            exp_cyc = int'(v.n_paths) * (2 * int'(v.n_steps) + 2) + 1 + stall_cnt;
            chk($sformatf("v%0d done_cycle", idx), 64'(done_cyc), 64'(exp_cyc));
        end
        chk($sformatf("v%0d en_pulses", idx), 64'(en_cnt), 64'(v.exp_en));
        if (v.n_steps == 16'd0)
            chk($sformatf("v%0d no_rng_ready", idx), 64'(ready_cnt), 64'd0);
        @(negedge clk);
        chk($sformatf("v%0d done_one_cycle", idx), 64'(done), 64'd0);
        chk($sformatf("v%0d busy_after", idx), 64'(busy), 64'd0);
        chk($sformatf("v%0d hold_sum", idx), 64'(payoff_sum), 64'(v.exp_sum));
    endtask

    initial begin
        int en_seen;
        int cyc;
        logic done_seen;

        //         N   M   S0            v0            K             put neg pat      sum           pc  en
        vecs[0] = '{16'd4, 16'd2, 32'h0100_0000, 32'h0080_0000, 32'h0180_0000, 1'b0, 1'b0, 4'b1111, 48'h0100_0000, 16'd2, 8};
        vecs[1] = '{16'd5, 16'd0, 32'h0100_0000, 32'h0080_0000, 32'h0080_0000, 1'b0, 1'b0, 4'b1111, 48'h0,         16'd0, 0};
        vecs[2] = '{16'd0, 16'd3, 32'h0180_0000, 32'h0080_0000, 32'h0100_0000, 1'b0, 1'b0, 4'b1111, 48'h0180_0000, 16'd3, 0};
        vecs[3] = '{16'd4, 16'd2, 32'h0100_0000, 32'h0080_0000, 32'h0300_0000, 1'b1, 1'b0, 4'b1111, 48'h0200_0000, 16'd2, 8};
        vecs[4] = '{16'd4, 16'd2, 32'h0100_0000, 32'h0080_0000, 32'h0300_0000, 1'b1, 1'b0, 4'b1001, 48'h0200_0000, 16'd2, 8};
        vecs[5] = '{16'd2, 16'd1, 32'h0100_0000, 32'h0080_0000, 32'h0100_0000, 1'b1, 1'b1, 4'b1111, 48'h0100_0000, 16'd1, 2};
        vecs[6] = '{16'd1, 16'd1, 32'h0100_0000, 32'h0080_0000, 32'h0200_0000, 1'b0, 1'b0, 4'b1111, 48'h0,         16'd1, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset rng_ready", 64'(rng_ready), 64'd0);
        chk("reset solver_en", 64'(solver_en), 64'd0);
        chk("reset payoff_sum", 64'(payoff_sum), 64'd0);
        chk("reset path_count", 64'(path_count), 64'd0);
        chk("reset solver_S", 64'(solver_S), 64'd0);
        chk("reset solver_v", 64'(solver_v), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset during WAIT of path 2 (after the 5th solver step is issued)
        @(posedge clk); #1;
        S0 = vecs[0].s0; v0 = vecs[0].v0; K = vecs[0].k; is_put = vecs[0].is_put;
        n_steps = vecs[0].n_steps; n_paths = vecs[0].n_paths; stub_neg = 1'b0;
        rng_valid = 1'b1;
        start = 1'b1;
        en_seen = 0;
        cyc = 0;
        while (en_seen < 5 && cyc < 200) begin
            @(negedge clk);
            if (solver_en) en_seen++;
            if (en_seen < 5) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            cyc++;
        end
        chk("rst_test reached_path2", 64'(en_seen), 64'd5);
        @(posedge clk); #1;
        start = 1'b0;
        chk("rst_test path_count_before", 64'(path_count), 64'd1);
        chk("rst_test sum_before", 64'(payoff_sum), 64'h0080_0000);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_test busy", 64'(busy), 64'd0);
        chk("rst_test solver_en", 64'(solver_en), 64'd0);
        chk("rst_test rng_ready", 64'(rng_ready), 64'd0);
        chk("rst_test payoff_sum", 64'(payoff_sum), 64'd0);
        chk("rst_test path_count", 64'(path_count), 64'd0);
        done_seen = done;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            done_seen = done_seen | done | busy;
        end
        chk("rst_test no_done_no_busy", 64'(done_seen), 64'd0);

        run_vec(7, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/heston_path_ctrl.md
Name: heston_path_ctrl

Overview:
- Monte-Carlo path sequencer for the Heston pricer. It sits directly around the Euler-step SDE solver.
- Holds the per-path state S(t) and v(t) and feeds them to the solver. It takes one Wiener-increment pair from the RNG per step, enables the solver, and captures the solver's registered outputs.
- After n_steps steps it computes the European payoff. It accumulates payoffs over n_paths paths and reports the sum; the mean is computed downstream.

Parameters:
- STEP_W, 16, width of step counter / n_steps
- PATH_W, 16, width of path counter / n_paths
- SUM_W, 48, payoff accumulator width (Q(SUM_W-24).24, signed)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- S0  in  32  initial stock price, Q8.24 signed
- v0  in  32  initial variance, Q8.24 signed
- K  in  32  strike, Q8.24 signed
- is_put  in  1  0 = call, 1 = put
- n_steps  in  STEP_W  Euler steps per path
- n_paths  in  PATH_W  number of paths
- rng_valid  in  1  RNG has a dW1/dW2 pair on its outputs (the data goes straight to the solver)
- rng_ready  out  1  controller consumes the pair this cycle when rng_valid is also high
- solver_en  out  1  to solver en
- solver_S  out  32  to solver S_in
- solver_v  out  32  to solver v_in
- solver_S_out  in  32  from solver S_out
- solver_v_out  in  32  from solver v_out
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of run
- payoff_sum  out  SUM_W  accumulated payoff, signed Q.24
- path_count  out  PATH_W  paths completed in the current/last run

Behaviour:
- Reset values: state IDLE; rng_ready, solver_en, busy, done = 0; S_reg, v_reg, payoff_sum, path_count, step_cnt = 0.
- solver_S = S_reg and solver_v = v_reg, driven combinationally.
- The solver registers its result on the posedge where en = 1, so its result is valid the following cycle.
- Configuration latch: on an accepted start, latch S0, v0, K, is_put, n_steps, n_paths, and clear payoff_sum and path_count.
- IDLE:
  - start=1 and n_paths==0: go to DONE.
  - start=1 otherwise: go to INIT.
  - start while busy is ignored.
- INIT: S_reg<=S0_l, v_reg<=v0_l, step_cnt<=0. Go to PAYOFF if n_steps_l==0, else STEP.
- STEP:
  - rng_ready=1 and solver_en = rng_valid.
  - If rng_valid: go to WAIT. Otherwise stay in STEP (stall). solver_en is never high without rng_valid.
- WAIT:
  - S_reg <= max(solver_S_out, 0); v_reg <= max(solver_v_out, 0) (full-truncation floor; negative means bit31=1).
  - step_cnt++.
  - Go to PAYOFF if step_cnt+1 == n_steps_l, else STEP.
- PAYOFF:
  - d = is_put ? K_l - S_reg : S_reg - K_l, computed as a 33-bit signed value.
  - payoff = d > 0 ? d : 0, sign-extended to SUM_W.
  - payoff_sum += payoff; path_count++.
  - Go to DONE if path_count+1 == n_paths_l, else INIT.
- DONE: done=1 for exactly one cycle, then go to IDLE. payoff_sum and path_count hold until the next accepted start.
- Latency, with rng_valid held high: done is high exactly n_paths*(2*n_steps+2)+1 cycles after the cycle start is sampled. Each stall cycle in STEP adds one cycle.
- Accumulator overflow wraps silently. Sizing SUM_W so that it cannot overflow is the integrator's job.
- Reset mid-run: on the next edge, return to IDLE with every reset value applied. No partial done is issued.

Decomposition:
- Shared package heston_pkg:
  - Q8.24 constants (FRAC_BITS=24, Q_ONE=32'h0100_0000);
  - state enum {IDLE, INIT, STEP, WAIT, PAYOFF, DONE};
  - function payoff_q824(S, K, is_put).
- One natural sub-module: heston_payoff_acc (payoff compute plus SUM_W accumulator with clear and add strobes).
- The SDE solver is instantiated by the parent, not inside this block.

Test Plan:
1. n_paths=0, start at cycle 0 -> done=1 at cycle 1; payoff_sum=0; path_count=0; solver_en never asserted.
2. n_steps=0, n_paths=3, S0=0x0180_0000, K=0x0100_0000, call, rng_valid=1 -> done at cycle 7; payoff_sum=0x0180_0000; no rng_ready.
3. Stub solver (S_out=S_in+0x0040_0000, one-cycle registered), N=4, M=2, S0=0x0100_0000, K=0x0180_0000, call -> each path ends at 0x0200_0000; payoff_sum=0x0100_0000; done at cycle 21; 8 solver_en pulses.
4. Same as 3 but put with K=0x0300_0000 -> payoff_sum=0x0200_0000; then rng_valid pattern 1,0,0,1,... -> solver_en only when rng_valid&&rng_ready; done delayed by exactly the number of stall cycles.
5. Stub returns v_out=0xFF00_0000 and S_out=0xFFF0_0000 -> next STEP shows solver_v=0 and solver_S=0; put with K=0x0100_0000 gives payoff 0x0100_0000.
6. rst asserted in WAIT of path 2 -> next cycle busy=0, solver_en=0, rng_ready=0, payoff_sum=0, path_count=0, no done; a following start runs cleanly to the expected result.
